// File: rtl/multiplier_pkg.sv
// Shared pipeline definitions for the Montgomery converters.
// Holds the pipeline depth, the per-stage record and a low-bit mask helper.
package multiplier_pkg;
  import params_pkg::*;

  localparam int PIPE_DEPTH = 5;

  typedef struct packed {
    logic [DATA_LENGTH-1:0] t;
    logic [DATA_LENGTH-1:0] m;
    logic                   valid;
    logic                   err;
  } mont_stage_t;

  // Returns 2^k - 1.
  function automatic logic [DATA_LENGTH-1:0] low_mask(input logic [DATA_LENGTH-1:0] k);
    low_mask = (DATA_LENGTH'(1) << k) - DATA_LENGTH'(1);
  endfunction

endpackage

// File: rtl/params_pkg.sv
// Global datapath parameters for the Dilithium arithmetic core.
// MONT_R2 is R^2 mod q for the configured modulus, with R = 2^MODULUS_LENGTH.
package params_pkg;

  localparam int DATA_LENGTH = 64;

  localparam logic [DATA_LENGTH-1:0] MODULUS        = 64'd8380417;
  localparam logic [DATA_LENGTH-1:0] MODULUS_LENGTH = 64'd23;
  localparam logic [DATA_LENGTH-1:0] MOD_INV        = 64'd8380415;
  localparam logic [DATA_LENGTH-1:0] MONT_R2        = 64'd49145;

endpackage

// File: rtl/montgomery_redc.sv
// Pipelined Montgomery reduction REDC(t) = t * R^-1 mod q, four registered stages.
// Shared between the native->Montgomery and Montgomery->native converters.
module montgomery_redc
  import params_pkg::*;
  import multiplier_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_LENGTH-1:0] t,
  input  logic                   t_valid,
  input  logic                   t_err,
  input  logic [DATA_LENGTH-1:0] q,
  input  logic [DATA_LENGTH-1:0] q_bl,
  input  logic [DATA_LENGTH-1:0] qinv,
  output logic [DATA_LENGTH-1:0] result,
  output logic                   result_valid,
  output logic                   result_err
);

  logic [DATA_LENGTH-1:0] mask;
  mont_stage_t            s2_reg, s2_next;
  mont_stage_t            s3_reg, s3_next;
  logic [DATA_LENGTH:0]   sum_tp;
  logic [DATA_LENGTH-1:0] u_reg, u_next;
  logic                   u_valid_reg, u_err_reg;
  logic [DATA_LENGTH-1:0] reduced;

  assign mask = low_mask(q_bl);

  always_comb begin
    s2_next       = '0;
    s2_next.t     = t;
    s2_next.m     = ((t & mask) * qinv) & mask;
    s2_next.valid = t_valid;
    s2_next.err   = t_err;

    // From S3 on, the m field carries the product p = m * q.
    s3_next       = '0;
    s3_next.t     = s2_reg.t;
    s3_next.m     = s2_reg.m * q;
    s3_next.valid = s2_reg.valid;
    s3_next.err   = s2_reg.err;
  end

  // The carry out of t + p is significant before the shift.
  assign sum_tp  = {1'b0, s3_reg.t} + {1'b0, s3_reg.m};
  assign u_next  = DATA_LENGTH'(sum_tp >> q_bl);
  assign reduced = (u_reg >= q) ? (u_reg - q) : u_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_reg       <= '0;
      s3_reg       <= '0;
      u_reg        <= '0;
      u_valid_reg  <= 1'b0;
      u_err_reg    <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      result_err   <= 1'b0;
    end else begin
      s2_reg       <= s2_next;
      s3_reg       <= s3_next;
      u_reg        <= u_next;
      u_valid_reg  <= s3_reg.valid;
      u_err_reg    <= s3_reg.err;
      result_valid <= u_valid_reg;
      result_err   <= u_valid_reg & u_err_reg;
      if (u_valid_reg) begin
        result <= u_err_reg ? '0 : reduced;
      end
    end
  end

endmodule

// File: rtl/montgomery_enc_pipelined.sv
// Native -> Montgomery form converter: result = REDC(x * R^2 mod q) = x * R mod q.
// Define MONT_ENC_RANGE_CHECK_EN to flag (and zero) outputs for inputs with x >= q.
module montgomery_enc_pipelined
  import params_pkg::*;
  import multiplier_pkg::*;
(
  input  logic                   CLK_pci_sys_clk_p,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [DATA_LENGTH-1:0] x_i,
  input  logic [DATA_LENGTH-1:0] q_i,
  input  logic [DATA_LENGTH-1:0] q_bl_i,
  input  logic [DATA_LENGTH-1:0] qinv_i,
  input  logic [DATA_LENGTH-1:0] r2_i,
  output logic [DATA_LENGTH-1:0] result_o,
  output logic                   valid_o,
  output logic                   err_o
);

  logic [DATA_LENGTH-1:0] t_reg, t_next;
  logic                   valid_reg;
  logic                   err_reg, err_next;

  // Both operands are below 2^32, so the truncated product is exact.
  assign t_next = x_i * r2_i;

`ifdef MONT_ENC_RANGE_CHECK_EN
  assign err_next = (x_i >= q_i);
`else
  assign err_next = 1'b0;
`endif

  always_ff @(posedge CLK_pci_sys_clk_p or negedge rst_ni) begin
    if (!rst_ni) begin
      t_reg     <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      t_reg     <= t_next;
      valid_reg <= start_i;
      err_reg   <= err_next;
    end
  end

  montgomery_redc u_redc (
    .clk          (CLK_pci_sys_clk_p),
    .rst_n        (rst_ni),
    .t            (t_reg),
    .t_valid      (valid_reg),
    .t_err        (err_reg),
    .q            (q_i),
    .q_bl         (q_bl_i),
    .qinv         (qinv_i),
    .result       (result_o),
    .result_valid (valid_o),
    .result_err   (err_o)
  );

endmodule

// File: tb/tb_montgomery_enc_pipelined.sv
// Scoreboard bench for montgomery_enc_pipelined (q = 8380417, k = 23).
// Expected results are queued at issue and checked, with latency, as valid_o appears.
module tb_montgomery_enc_pipelined;

  localparam logic [63:0] Q     = 64'd8380417;
  localparam logic [63:0] K     = 64'd23;
  localparam logic [63:0] QINV  = 64'd8380415;
  localparam logic [63:0] R2    = 64'd49145;
  localparam int          DEPTH = 5;

  logic        clk;
  logic        rst_ni;
  logic        start_i;
  logic [63:0] x_i;
  logic [63:0] q_i, q_bl_i, qinv_i, r2_i;
  logic [63:0] result_o;
  logic        valid_o;
  logic        err_o;

  typedef struct {
    logic [63:0] x;
    logic [63:0] res;
    logic        err;
    int          issue_cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  montgomery_enc_pipelined dut (
    .CLK_pci_sys_clk_p (clk),
    .rst_ni            (rst_ni),
    .start_i           (start_i),
    .x_i               (x_i),
    .q_i               (q_i),
    .q_bl_i            (q_bl_i),
    .qinv_i            (qinv_i),
    .r2_i              (r2_i),
    .result_o          (result_o),
    .valid_o           (valid_o),
    .err_o             (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every valid_o must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (valid_o === 1'b1) begin
      tests_run++;
      if (sb_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_valid: result_o=%0d err_o=%0b with no outstanding input, required valid_o=0",
                 result_o, err_o);
      end else begin
        mon_e = sb_q.pop_front();
        if (result_o !== mon_e.res || err_o !== mon_e.err || (cyc - mon_e.issue_cyc) != DEPTH) begin
          tests_failed++;
          $display("FAIL result x=%0d: got result=%0d err=%0b latency=%0d, required result=%0d err=%0b latency=%0d",
                   mon_e.x, result_o, err_o, cyc - mon_e.issue_cyc, mon_e.res, mon_e.err, DEPTH);
        end else begin
          $display("[TB] x=%0d -> result=%0d err=%0b latency=%0d", mon_e.x, result_o, err_o, DEPTH);
        end
      end
    end
  end

  function automatic logic [63:0] model(input logic [63:0] x);
    longint unsigned xs;
    xs = longint'(x) << 23;
    return 64'(xs % longint'(Q));
  endfunction

  task automatic issue(input logic [63:0] x, input logic [63:0] r, input logic e);
    exp_t it;
    @(negedge clk);
    start_i = 1'b1;
    x_i     = x;
    it.x = x; it.res = r; it.err = e; it.issue_cyc = cyc;
    sb_q.push_back(it);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start_i = 1'b0;
      x_i     = '0;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    idle(1);
    while (sb_q.size() != 0 && n < 20) begin
      idle(1);
      n++;
    end
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain_%s: %0d results outstanding, required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset;
    #1;
    tests_run += 3;
    if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0b, required 0", valid_o); end
    if (result_o !== 64'd0) begin tests_failed++; $display("FAIL reset_result: got %0d, required 0", result_o); end
    if (err_o !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %0b, required 0", err_o); end
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    idle(DEPTH + 2);
  endtask

  task automatic test_single;
    issue(64'd0, 64'd0, 1'b0);
    drain("x0");
    issue(64'd1, 64'd8191, 1'b0);
    drain("x1");
    issue(64'd1000, 64'd8191000, 1'b0);
    drain("x1000");
  endtask

  task automatic test_boundary;
    issue(Q - 64'd1, 64'd8372226, 1'b0);
    drain("q_minus_1");
  endtask

  task automatic test_back_to_back;
    issue(64'd1, 64'd8191, 1'b0);
    issue(64'd2, 64'd16382, 1'b0);
    issue(64'd3, 64'd24573, 1'b0);
    drain("b2b");
  endtask

  task automatic test_gap;
    issue(64'd5, 64'd40955, 1'b0);
    idle(1);
    issue(64'd7, 64'd57337, 1'b0);
    drain("gap");
    // result_o must hold the last value while valid_o is low
    repeat (3) begin
      @(negedge clk);
      tests_run++;
      if (result_o !== 64'd57337 || valid_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold: got result=%0d valid=%0b, required result=57337 valid=0", result_o, valid_o);
      end
    end
  endtask

  task automatic test_random;
    logic [63:0] x;
    for (int i = 0; i < 24; i++) begin
      x = 64'($urandom_range(32'd8380416, 32'd0));
      if (i == 0) x = Q - 64'd2;
      issue(x, model(x), 1'b0);
      if ($urandom_range(3, 0) == 0) idle($urandom_range(2, 1));
    end
    drain("random");
  endtask

  task automatic test_async_reset;
    issue(64'd3, 64'd24573, 1'b0);
    issue(64'd4, 64'd32764, 1'b0);
    @(negedge clk);
    start_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    sb_q.delete();
    #1;
    tests_run += 3;
    if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL async_reset_valid: got %0b, required 0", valid_o); end
    if (result_o !== 64'd0) begin tests_failed++; $display("FAIL async_reset_result: got %0d, required 0", result_o); end
    if (err_o !== 1'b0) begin tests_failed++; $display("FAIL async_reset_err: got %0b, required 0", err_o); end
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    idle(DEPTH + 4);
    issue(64'd2, 64'd16382, 1'b0);
    drain("after_reset");
  endtask

`ifdef MONT_ENC_RANGE_CHECK_EN
  task automatic test_range_check;
    issue(Q, 64'd0, 1'b1);
    issue(64'd1, 64'd8191, 1'b0);
    drain("range");
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni  = 1'b0;
    start_i = 1'b0;
    x_i     = '0;
    q_i     = Q;
    q_bl_i  = K;
    qinv_i  = QINV;
    r2_i    = R2;

    test_reset();
    test_single();
    test_boundary();
    test_back_to_back();
    test_gap();
    test_async_reset();
    test_random();
`ifdef MONT_ENC_RANGE_CHECK_EN
    test_range_check();
`endif
    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
